serial_paralelo_rx: RTL

// - Deserializer directly downstream of the parallel-to-serial transmitter: takes the 1-bit line
//   at clk8f, finds byte alignment from the 0xBC comma idle, rebuilds 8-bit words plus a valid bit.
// - Output mirrors the transmitter's 9-bit input format: {valid, data[7:0]}.
// - Feeds the receive-side lane/demux logic; asserts active once the link is synchronised.

---
 rtl/serial_paralelo_rx_if.sv | 13 +
 rtl/serial_paralelo_rx.sv | 134 +++++++++++++
 2 files changed

// File: rtl/serial_paralelo_rx_if.sv
// Receive-side bundle of the serial-to-parallel deserializer: serial line in, {valid,data} word out.
// byte_stb is a valid-only strobe with no ready: the consumer must take paralelo_out in the strobe cycle.
interface serial_paralelo_rx_if;
  logic       serial_in;
  logic [8:0] paralelo_out;
  logic       byte_stb;
  logic       active;
  logic       sync_err;
  logic [1:0] state_dbg;

  modport master (output serial_in, input paralelo_out, byte_stb, active, sync_err, state_dbg);
  modport slave  (input serial_in, output paralelo_out, byte_stb, active, sync_err, state_dbg);
endinterface

// File: rtl/serial_paralelo_rx.sv
// Deserializer: aligns to the COMMA idle symbol, then rebuilds {valid, data[7:0]} words at clk8f.
// Optional SP_RESYNC_EN: loss of alignment / stuck line returns to SEARCH with a sync_err pulse.
module serial_paralelo_rx #(
  parameter logic [7:0] COMMA    = 8'hBC,
  parameter int         BC_COUNT = 4
) (
  input logic                 clk8f,
  input logic                 reset_L,
  serial_paralelo_rx_if.slave rx
);
  typedef enum logic [1:0] {SEARCH = 2'b00, ALIGNED = 2'b01, ACTIVE = 2'b10} state_t;
  localparam logic [3:0] BC_LIM = 4'(BC_COUNT);

  state_t     state;
  logic [7:0] sr;
  logic [2:0] bit_cnt;
  logic [3:0] bc_cnt;
  logic [8:0] out_q;
  logic       stb_q;
  logic       active_q;
  logic       err_q;
  logic [7:0] nxt;
  logic       is_comma;
  logic       boundary;

  assign nxt      = {sr[6:0], rx.serial_in};
  assign is_comma = (nxt == COMMA);
  assign boundary = (bit_cnt == 3'd7);

`ifdef SP_RESYNC_EN
  logic [2:0] stuck_cnt;
  logic       stuck;
  assign stuck = (nxt == 8'h00) || (nxt == 8'hFF);
`endif

  always_ff @(posedge clk8f or negedge reset_L) begin
    if (!reset_L) begin
      state    <= SEARCH;
      sr       <= 8'h00;
      bit_cnt  <= 3'd0;
      bc_cnt   <= 4'd0;
      out_q    <= 9'h000;
      stb_q    <= 1'b0;
      active_q <= 1'b0;
      err_q    <= 1'b0;
`ifdef SP_RESYNC_EN
      stuck_cnt <= 3'd0;
`endif
    end else begin
      sr    <= nxt;
      stb_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        SEARCH: begin
          // Any bit offset may hold the comma; its last bit defines the byte phase.
          if (is_comma) begin
            bit_cnt <= 3'd0;
            bc_cnt  <= 4'd1;
`ifdef SP_RESYNC_EN
            stuck_cnt <= 3'd0;
`endif
            if (BC_LIM == 4'd1) begin
              state    <= ACTIVE;
              active_q <= 1'b1;
            end else begin
              state <= ALIGNED;
            end
          end
        end
        ALIGNED: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            if (is_comma) begin
              if (bc_cnt + 4'd1 >= BC_LIM) begin
                state    <= ACTIVE;
                active_q <= 1'b1;
                bc_cnt   <= BC_LIM;
              end else begin
                bc_cnt <= bc_cnt + 4'd1;
              end
            end else begin
              bc_cnt <= 4'd0;
`ifdef SP_RESYNC_EN
              state   <= SEARCH;
              bit_cnt <= 3'd0;
              err_q   <= 1'b1;
`endif
            end
          end
        end
        ACTIVE: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
`ifdef SP_RESYNC_EN
            // Eight all-0/all-1 bytes in a row means the line is dead, not data.
            if (stuck && stuck_cnt == 3'd7) begin
              state     <= SEARCH;
              active_q  <= 1'b0;
              err_q     <= 1'b1;
              bc_cnt    <= 4'd0;
              bit_cnt   <= 3'd0;
              stuck_cnt <= 3'd0;
            end else begin
              stuck_cnt <= stuck ? stuck_cnt + 3'd1 : 3'd0;
              out_q     <= {~is_comma, nxt};
              stb_q     <= 1'b1;
            end
`else
            out_q <= {~is_comma, nxt};
            stb_q <= 1'b1;
`endif
          end
        end
        default: begin
          state    <= SEARCH;
          active_q <= 1'b0;
          bit_cnt  <= 3'd0;
          bc_cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign rx.paralelo_out = out_q;
  assign rx.byte_stb     = stb_q;
  assign rx.active       = active_q;
  assign rx.state_dbg    = state;
`ifdef SP_RESYNC_EN
  assign rx.sync_err = err_q;
`else
  assign rx.sync_err = 1'b0;
`endif

endmodule
